axis_orthogonal_merge: RTL and testbench



---
 rtl/axis_orthogonal_merge.sv | 133 +++++++++++++
 tb/tb_axis_orthogonal_merge.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_orthogonal_merge.sv
// N-to-1 packet merger for mutually exclusive AXI-stream lanes: round-robin grant, lane locked through tlast.
// Optional overlap checker enabled by defining AXIS_ORTHO_MERGE_CHK_EN.
module axis_orthogonal_merge #(
  parameter int NUM   = 8,
  parameter int DSIZE = 32,
  parameter int IDW   = $clog2(NUM)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NUM-1:0]       s_tvalid,
  output logic [NUM-1:0]       s_tready,
  input  logic [NUM*DSIZE-1:0] s_tdata,
  input  logic [NUM-1:0]       s_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [DSIZE-1:0]     m_tdata,
  output logic                 m_tlast,
  output logic [IDW-1:0]       m_tuser,
  output logic                 err_overlap,
  output logic [15:0]          err_cnt
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   sel_q, sel_d, ptr_q, ptr_d, pick;
  logic             m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
  logic [DSIZE-1:0] m_tdata_q, m_tdata_d;
  logic [IDW-1:0]   m_tuser_q, m_tuser_d;
  logic             lane_rdy, accept;

  // Walk downward so the lowest offset from ptr wins the final assignment.
  always_comb begin
    pick = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (s_tvalid[(int'(ptr_q) + i) % NUM]) pick = IDW'((int'(ptr_q) + i) % NUM);
    end
  end

  assign lane_rdy = ~m_tvalid_q | m_tready;
  assign accept   = (state_q == LOCK) & s_tvalid[sel_q] & lane_rdy;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    m_tuser_d  = m_tuser_q;
    s_tready   = '0;
    case (state_q)
      IDLE: begin
        if (|s_tvalid) begin
          sel_d   = pick;
          state_d = LOCK;
        end
      end
      LOCK: begin
        s_tready[sel_q] = lane_rdy;
        if (accept && s_tlast[sel_q]) begin
          state_d = IDLE;
          ptr_d   = (sel_q == IDW'(NUM - 1)) ? '0 : sel_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A load wins over a drain so back-to-back beats keep valid high.
    if (accept) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = s_tdata[sel_q*DSIZE +: DSIZE];
      m_tlast_d  = s_tlast[sel_q];
      m_tuser_d  = sel_q;
    end else if (m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      ptr_q      <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
      m_tuser_q  <= m_tuser_d;
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign m_tlast  = m_tlast_q;
  assign m_tuser  = m_tuser_q;

`ifdef AXIS_ORTHO_MERGE_CHK_EN
  logic        overlap;
  logic        err_overlap_q, err_overlap_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    overlap       = $countones(s_tvalid) > 1;
    err_overlap_d = err_overlap_q | overlap;
    err_cnt_d     = err_cnt_q;
    if (overlap && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      err_overlap_q <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      err_overlap_q <= err_overlap_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign err_overlap = err_overlap_q;
  assign err_cnt     = err_cnt_q;
`else
  assign err_overlap = 1'b0;
  assign err_cnt     = '0;
`endif

endmodule

// File: tb/tb_axis_orthogonal_merge.sv
// Randomized + directed bench for axis_orthogonal_merge against a packet-level reference model.
module tb_axis_orthogonal_merge;
  localparam int NUM = 4, DSIZE = 32, IDW = 2;

  logic                 clock = 1'b0, rst = 1'b1;
  logic [NUM-1:0]       s_tvalid, s_tready, s_tlast;
  logic [NUM*DSIZE-1:0] s_tdata;
  logic                 m_tvalid, m_tready, m_tlast, err_overlap;
  logic [DSIZE-1:0]     m_tdata;
  logic [IDW-1:0]       m_tuser;
  logic [15:0]          err_cnt;

  axis_orthogonal_merge #(.NUM(NUM), .DSIZE(DSIZE), .IDW(IDW)) dut (
    .clock(clock), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tlast(s_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .err_overlap(err_overlap), .err_cnt(err_cnt));

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // stimulus sources: one queue of {last, data} per lane
  logic [32:0]    lq [NUM][$];
  logic [NUM-1:0] en;
  logic           mrdy, rst_now;
  int cyc = 0, pushed = 0, out_beats = 0, first_sv = -1, first_mv = -1;
  int out_lanes[$];

  // reference model: packet-level grant state and output register
  bit          m_idle = 1, mv = 0, mlast = 0, ovl_flag = 0;
  int          m_sel = 0, m_ptr = 0, muser = 0, ovl = 0;
  logic [31:0] mdata = '0;

  function automatic int rr_pick(input logic [NUM-1:0] v, input int p);
    for (int i = 0; i < NUM; i++) if (v[(p + i) % NUM]) return (p + i) % NUM;
    return 0;
  endfunction

  function automatic bit busy();
    for (int k = 0; k < NUM; k++) if (lq[k].size() > 0) return 1;
    return mv;
  endfunction

  task automatic push_pkt(input int lane, input int len);
    for (int i = 0; i < len; i++) begin
      lq[lane].push_back({(i == len - 1), 8'(lane), 8'(pushed), 16'($urandom)});
      pushed++;
    end
  endtask

  task automatic cycle();
    logic [NUM-1:0] vld, exp_rdy;
    int acc;
    bit idle_now;
    @(negedge clock);
    vld = '0;
    for (int k = 0; k < NUM; k++) begin
      if (!rst_now && en[k] && lq[k].size() > 0) vld[k] = 1'b1;
      s_tdata[k*DSIZE +: DSIZE] = (lq[k].size() > 0) ? lq[k][0][31:0] : '0;
      s_tlast[k] = (lq[k].size() > 0) ? lq[k][0][32] : 1'b0;
    end
    s_tvalid = vld; m_tready = mrdy; rst = rst_now;
    #1;
    exp_rdy = '0;
    if (!m_idle) exp_rdy[m_sel] = !mv || mrdy;
    chk("s_tready", s_tready, exp_rdy);
    chk("m_tvalid", m_tvalid, mv);
    if (mv) begin
      chk("m_tdata", m_tdata, mdata);
      chk("m_tlast", m_tlast, mlast);
      chk("m_tuser", m_tuser, muser);
    end
    if (|vld && first_sv < 0) first_sv = cyc;
    if (m_tvalid && first_mv < 0) first_mv = cyc;
    acc = -1;
    for (int k = 0; k < NUM; k++) if (vld[k] && s_tready[k]) acc = k;
    idle_now = m_idle;
    if (m_tvalid && mrdy) begin
      out_lanes.push_back(int'(m_tuser));
      out_beats++;
    end
    if (rst_now) begin
      m_idle = 1; m_ptr = 0; m_sel = 0; mv = 0; mdata = '0; mlast = 0; muser = 0;
      ovl = 0; ovl_flag = 0;
    end else begin
      if ($countones(vld) > 1) begin
        ovl_flag = 1;
        if (ovl < 65535) ovl++;
      end
      if (acc >= 0) begin
        mv = 1; mdata = lq[acc][0][31:0]; mlast = lq[acc][0][32]; muser = acc;
        if (mlast) begin m_idle = 1; m_ptr = (acc + 1) % NUM; end
        void'(lq[acc].pop_front());
      end else if (mrdy) mv = 0;
      if (idle_now && |vld) begin m_sel = rr_pick(vld, m_ptr); m_idle = 0; end
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_now = 1; cycle(); rst_now = 0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    en = '1; mrdy = 1;
    while (busy() && n < budget) begin cycle(); n++; end
    if (n >= budget) chk("drain_timeout", 1, 0);
  endtask

  task automatic chk_err(input string tag);
    @(posedge clock); #1;
`ifdef AXIS_ORTHO_MERGE_CHK_EN
    chk({tag, "_cnt"}, err_cnt, ovl);
    chk({tag, "_flag"}, err_overlap, ovl_flag);
`else
    chk({tag, "_cnt"}, err_cnt, 0);
    chk({tag, "_flag"}, err_overlap, 0);
`endif
  endtask

  initial begin
    int base, n;
    bit pat [6] = '{1, 0, 0, 1, 1, 1};
    rst_now = 1; en = '0; mrdy = 1; s_tvalid = '0; s_tdata = '0; s_tlast = '0; m_tready = 1'b0;
    cycle(); cycle(); rst_now = 0;
    @(posedge clock); #1;
    chk("rst_m_tvalid", m_tvalid, 0); chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);   chk("rst_m_tuser", m_tuser, 0);
    chk("rst_s_tready", s_tready, 0); chk("rst_err_ovl", err_overlap, 0);
    chk("rst_err_cnt", err_cnt, 0);

    // single lane, 3 beats
    first_sv = -1; first_mv = -1; out_lanes.delete();
    push_pkt(2, 3); drain(50);
    chk("single_latency", first_mv - first_sv, 2);
    chk("single_beats", out_lanes.size(), 3);
    foreach (out_lanes[i]) chk("single_lane", out_lanes[i], 2);

    // round-robin from ptr=0, then wrap back to 0
    do_reset(); out_lanes.delete();
    push_pkt(0, 2); push_pkt(3, 2); drain(50);
    chk("rr_beats", out_lanes.size(), 4);
    if (out_lanes.size() == 4) begin
      chk("rr_0", out_lanes[0], 0); chk("rr_1", out_lanes[1], 0);
      chk("rr_2", out_lanes[2], 3); chk("rr_3", out_lanes[3], 3);
    end
    out_lanes.delete();
    push_pkt(3, 2); push_pkt(0, 2); drain(50);
    chk("rr_wrap_first", (out_lanes.size() > 0) ? out_lanes[0] : -1, 0);

    // backpressure
    base = out_beats; push_pkt(1, 4); en = '1;
    for (int i = 0; i < 6; i++) begin mrdy = pat[i]; cycle(); end
    drain(50);
    chk("bp_beats", out_beats - base, 4);

    // bubbles on lane 1 with lane 0 waiting, then single-beat packet
    out_lanes.delete(); push_pkt(1, 5); en = '1; mrdy = 1;
    cycle(); cycle(); cycle();
    push_pkt(0, 1); en = 4'b1101;
    cycle(); cycle(); cycle();
    drain(50);
    chk("bubble_beats", out_lanes.size(), 6);
    if (out_lanes.size() == 6) begin
      chk("bubble_lane1", out_lanes[4], 1); chk("bubble_lane0", out_lanes[5], 0);
    end
    base = out_beats; push_pkt(2, 1); drain(50);
    chk("single_beat", out_beats - base, 1);

    // reset mid-packet after 2 of 5 beats
    base = out_beats; push_pkt(1, 5); en = '1; n = 0;
    while (lq[1].size() > 3 && n < 20) begin cycle(); n++; end
    chk("rstmid_reach", lq[1].size(), 3);
    do_reset();
    @(posedge clock); #1;
    chk("rstmid_m_tvalid", m_tvalid, 0); chk("rstmid_s_tready", s_tready, 0);
    chk("rstmid_m_tuser", m_tuser, 0);
    drain(50);
    chk("rstmid_beats", out_beats - base, 5);

    // overlap: exactly 5 cycles of lanes 0 and 1 valid together
    do_reset(); push_pkt(0, 8); push_pkt(1, 8); en = '1; mrdy = 1;
    for (int i = 0; i < 5; i++) cycle();
    en = 4'b1101; n = 0;
    while (lq[0].size() > 0 && n < 30) begin cycle(); n++; end
    chk_err("ovl");
`ifdef AXIS_ORTHO_MERGE_CHK_EN
    chk("ovl_cnt5", err_cnt, 5);
`else
    chk("ovl_cnt0", err_cnt, 0);
`endif
    drain(50);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NUM; k++)
        if (lq[k].size() < 2 && $urandom_range(0, 3) == 0) push_pkt(k, $urandom_range(1, 4));
      en = NUM'($urandom); mrdy = ($urandom_range(0, 9) < 7);
      cycle();
    end
    drain(500);
    chk_err("end");
    chk("total_beats", out_beats, pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
